// File: rtl/icache_fill_unit.sv
// Icache miss-handling stage: one outstanding block read, one-cycle fill pulse, flush draining.
// Optional macro ICACHE_FILL_TIMEOUT_EN adds a WAIT timeout with re-request and sticky timeout_err.
module icache_fill_unit #(
    parameter int unsigned ADDR_WIDTH         = 32,
    parameter int unsigned BLOCK_OFFSET_WIDTH = 3,
    parameter int unsigned BLOCK_DATA_WIDTH   = 64,
    parameter int unsigned INDEX_WIDTH        = 6,
    parameter int unsigned TIMEOUT_CYCLES     = 64
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic                                             miss_valid,
    input  logic [ADDR_WIDTH-1:0]                            miss_addr,
    input  logic                                             miss_victim_way,
    output logic                                             miss_ready,
    input  logic                                             flush,
    output logic                                             mem_req_valid,
    input  logic                                             mem_req_ready,
    output logic [ADDR_WIDTH-BLOCK_OFFSET_WIDTH-1:0]         mem_req_block_addr,
    input  logic                                             mem_resp_valid,
    input  logic [ADDR_WIDTH-BLOCK_OFFSET_WIDTH-1:0]         mem_resp_block_addr,
    input  logic [BLOCK_DATA_WIDTH-1:0]                      mem_resp_data,
    output logic                                             fill_valid,
    output logic                                             fill_way,
    output logic [INDEX_WIDTH-1:0]                           fill_index,
    output logic [ADDR_WIDTH-BLOCK_OFFSET_WIDTH-INDEX_WIDTH-1:0] fill_tag,
    output logic [BLOCK_DATA_WIDTH-1:0]                      fill_data,
`ifdef ICACHE_FILL_TIMEOUT_EN
    output logic                                             timeout_err,
`endif
    output logic                                             busy
);

    localparam int unsigned BLK_W = ADDR_WIDTH - BLOCK_OFFSET_WIDTH;

    if (BLOCK_DATA_WIDTH != (8 << BLOCK_OFFSET_WIDTH)) begin : g_bad_data_width
        $error("BLOCK_DATA_WIDTH must equal 8 << BLOCK_OFFSET_WIDTH");
    end
    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be nonzero");
    end

    typedef enum logic [2:0] {StIdle, StReq, StWait, StFill, StDrain} state_e;

    state_e                      state_q, state_d;
    logic [BLK_W-1:0]            blk_q, blk_d;
    logic                        way_q, way_d;
    logic [BLOCK_DATA_WIDTH-1:0] data_q, data_d;
    logic                        resp_match;

    // Byte offset only selects within the block; the whole block is always fetched.
    logic unused_offset;
    assign unused_offset = ^miss_addr[BLOCK_OFFSET_WIDTH-1:0];

    assign resp_match = mem_resp_valid && (mem_resp_block_addr == blk_q);

`ifdef ICACHE_FILL_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             terr_q, terr_d;
    logic             timeout_hit;

    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign timeout_err = terr_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            blk_q   <= '0;
            way_q   <= 1'b0;
            data_q  <= '0;
`ifdef ICACHE_FILL_TIMEOUT_EN
            cnt_q   <= '0;
            terr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            blk_q   <= blk_d;
            way_q   <= way_d;
            data_q  <= data_d;
`ifdef ICACHE_FILL_TIMEOUT_EN
            cnt_q   <= cnt_d;
            terr_q  <= terr_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        blk_d   = blk_q;
        way_d   = way_q;
        data_d  = data_q;
`ifdef ICACHE_FILL_TIMEOUT_EN
        // Counter is zero everywhere except while waiting, so entering WAIT starts from zero.
        cnt_d   = '0;
        terr_d  = terr_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (miss_valid && !flush) begin
                    blk_d   = miss_addr[ADDR_WIDTH-1:BLOCK_OFFSET_WIDTH];
                    way_d   = miss_victim_way;
                    state_d = StReq;
                end
            end
            StReq: begin
                // A flush on the handshake cycle still leaves a response to be drained.
                if (mem_req_ready) begin
                    state_d = flush ? StDrain : StWait;
                end else if (flush) begin
                    state_d = StIdle;
                end
            end
            StWait: begin
                if (resp_match) begin
                    data_d  = mem_resp_data;
                    state_d = flush ? StIdle : StFill;
                end else if (flush) begin
                    state_d = StDrain;
`ifdef ICACHE_FILL_TIMEOUT_EN
                end else if (timeout_hit) begin
                    state_d = StReq;
                    terr_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
`endif
                end
            end
            StFill: begin
                state_d = StIdle;
            end
            StDrain: begin
                if (resp_match) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        miss_ready         = (state_q == StIdle);
        busy               = (state_q != StIdle);
        mem_req_valid      = (state_q == StReq);
        mem_req_block_addr = '0;
        fill_valid         = (state_q == StFill);
        fill_way           = 1'b0;
        fill_index         = '0;
        fill_tag           = '0;
        fill_data          = '0;
        if (state_q == StReq) begin
            mem_req_block_addr = blk_q;
        end
        if (state_q == StFill) begin
            fill_way   = way_q;
            fill_index = blk_q[INDEX_WIDTH-1:0];
            fill_tag   = blk_q[BLK_W-1:INDEX_WIDTH];
            fill_data  = data_q;
        end
    end

endmodule

// File: tb/tb_icache_fill_unit.sv
// Self-checking bench for icache_fill_unit: transaction-level model, directed cases, random traffic.
module tb_icache_fill_unit;

    localparam int unsigned AW = 32;
    localparam int unsigned OW = 3;
    localparam int unsigned DW = 64;
    localparam int unsigned IW = 6;
    localparam int unsigned BW = AW - OW;
    localparam int unsigned TW = BW - IW;
`ifdef ICACHE_FILL_TIMEOUT_EN
    localparam int unsigned TO = 8;
`else
    localparam int unsigned TO = 64;
`endif

    logic          clk;
    logic          rst;
    logic          miss_valid;
    logic [AW-1:0] miss_addr;
    logic          miss_victim_way;
    logic          miss_ready;
    logic          flush;
    logic          mem_req_valid;
    logic          mem_req_ready;
    logic [BW-1:0] mem_req_block_addr;
    logic          mem_resp_valid;
    logic [BW-1:0] mem_resp_block_addr;
    logic [DW-1:0] mem_resp_data;
    logic          fill_valid;
    logic          fill_way;
    logic [IW-1:0] fill_index;
    logic [TW-1:0] fill_tag;
    logic [DW-1:0] fill_data;
    logic          busy;
`ifdef ICACHE_FILL_TIMEOUT_EN
    logic          timeout_err;
`endif

    icache_fill_unit #(
        .ADDR_WIDTH         (AW),
        .BLOCK_OFFSET_WIDTH (OW),
        .BLOCK_DATA_WIDTH   (DW),
        .INDEX_WIDTH        (IW),
        .TIMEOUT_CYCLES     (TO)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .miss_valid          (miss_valid),
        .miss_addr           (miss_addr),
        .miss_victim_way     (miss_victim_way),
        .miss_ready          (miss_ready),
        .flush               (flush),
        .mem_req_valid       (mem_req_valid),
        .mem_req_ready       (mem_req_ready),
        .mem_req_block_addr  (mem_req_block_addr),
        .mem_resp_valid      (mem_resp_valid),
        .mem_resp_block_addr (mem_resp_block_addr),
        .mem_resp_data       (mem_resp_data),
        .fill_valid          (fill_valid),
        .fill_way            (fill_way),
        .fill_index          (fill_index),
        .fill_tag            (fill_tag),
        .fill_data           (fill_data),
`ifdef ICACHE_FILL_TIMEOUT_EN
        .timeout_err         (timeout_err),
`endif
        .busy                (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;
    int dut_hs = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Transaction view: is a miss open, has its request gone out, was it abandoned, is a fill due.
    bit            m_active;
    bit            m_issued;
    bit            m_dropped;
    bit            m_fill;
    bit            m_terr;
    bit            m_way;
    logic [BW-1:0] m_blk;
    logic [DW-1:0] m_data;
    int            m_wait;
    logic          m_match;

    assign m_match = mem_resp_valid && (mem_resp_block_addr == m_blk);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active  <= 1'b0;
            m_issued  <= 1'b0;
            m_dropped <= 1'b0;
            m_fill    <= 1'b0;
            m_terr    <= 1'b0;
            m_way     <= 1'b0;
            m_blk     <= '0;
            m_data    <= '0;
            m_wait    <= 0;
        end else if (!m_active) begin
            if (miss_valid && !flush) begin
                m_active  <= 1'b1;
                m_issued  <= 1'b0;
                m_dropped <= 1'b0;
                m_blk     <= miss_addr[AW-1:OW];
                m_way     <= miss_victim_way;
            end
        end else if (m_fill) begin
            m_fill   <= 1'b0;
            m_active <= 1'b0;
        end else if (!m_issued) begin
            if (mem_req_ready) begin
                m_issued  <= 1'b1;
                m_dropped <= flush;
                m_wait    <= 0;
            end else if (flush) begin
                m_active <= 1'b0;
            end
        end else if (m_dropped) begin
            if (m_match) m_active <= 1'b0;
        end else if (m_match) begin
            if (flush) begin
                m_active <= 1'b0;
            end else begin
                m_fill <= 1'b1;
                m_data <= mem_resp_data;
            end
        end else if (flush) begin
            m_dropped <= 1'b1;
`ifdef ICACHE_FILL_TIMEOUT_EN
        end else if (m_wait == int'(TO) - 1) begin
            m_issued <= 1'b0;
            m_terr   <= 1'b1;
        end else begin
            m_wait <= m_wait + 1;
`endif
        end
    end

    always @(posedge clk) begin
        if (rst === 1'b0 && mem_req_valid && mem_req_ready) dut_hs <= dut_hs + 1;
    end

    // Outputs depend only on registered state, so sampling on the falling edge is stable.
    always @(negedge clk) begin
        chk("miss_ready", 64'(miss_ready), 64'(!m_active));
        chk("busy", 64'(busy), 64'(m_active));
        chk("mem_req_valid", 64'(mem_req_valid), 64'(m_active && !m_issued));
        chk("fill_valid", 64'(fill_valid), 64'(m_fill));
        if (m_active && !m_issued) chk("mem_req_block_addr", 64'(mem_req_block_addr), 64'(m_blk));
        if (m_fill) begin
            chk("fill_way", 64'(fill_way), 64'(m_way));
            chk("fill_index", 64'(fill_index), 64'(m_blk % (1 << IW)));
            chk("fill_tag", 64'(fill_tag), 64'(m_blk >> IW));
            chk("fill_data", 64'(fill_data), 64'(m_data));
        end
`ifdef ICACHE_FILL_TIMEOUT_EN
        chk("timeout_err", 64'(timeout_err), 64'(m_terr));
`endif
    end

    task automatic issue_miss(input logic [AW-1:0] a, input logic w);
        miss_valid      = 1'b1;
        miss_addr       = a;
        miss_victim_way = w;
        @(negedge clk);
        miss_valid = 1'b0;
    endtask

    task automatic respond(input logic [BW-1:0] b, input logic [DW-1:0] d);
        mem_resp_valid      = 1'b1;
        mem_resp_block_addr = b;
        mem_resp_data       = d;
        @(negedge clk);
        mem_resp_valid = 1'b0;
    endtask

    initial begin
        int hs0;
        rst                 = 1'b1;
        miss_valid          = 1'b0;
        miss_addr           = '0;
        miss_victim_way     = 1'b0;
        flush               = 1'b0;
        mem_req_ready       = 1'b1;
        mem_resp_valid      = 1'b0;
        mem_resp_block_addr = '0;
        mem_resp_data       = '0;
        repeat (2) @(negedge clk);
        chk("rst_miss_ready", 64'(miss_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_req_valid", 64'(mem_req_valid), 64'd0);
        chk("rst_req_addr", 64'(mem_req_block_addr), 64'd0);
        chk("rst_fill_valid", 64'(fill_valid), 64'd0);
        chk("rst_fill_data", 64'(fill_data), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic miss
        issue_miss(32'h0001_018c, 1'b1);
        chk("basic_req_valid", 64'(mem_req_valid), 64'd1);
        chk("basic_req_addr", 64'(mem_req_block_addr), 64'h2031);
        @(negedge clk);
        chk("basic_req_done", 64'(mem_req_valid), 64'd0);
        @(negedge clk);
        respond(29'h2031, 64'h0081_2e23_fe01_0113);
        chk("basic_fill", 64'(fill_valid), 64'd1);
        chk("basic_index", 64'(fill_index), 64'h31);
        chk("basic_tag", 64'(fill_tag), 64'h80);
        chk("basic_way", 64'(fill_way), 64'd1);
        chk("basic_data", fill_data, 64'h0081_2e23_fe01_0113);
        chk("basic_ready_low", 64'(miss_ready), 64'd0);
        @(negedge clk);
        chk("basic_fill_once", 64'(fill_valid), 64'd0);
        chk("basic_ready_back", 64'(miss_ready), 64'd1);

        // Backpressure
        mem_req_ready = 1'b0;
        hs0 = dut_hs;
        issue_miss(32'h0001_018c, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("bp_req_held", 64'(mem_req_valid), 64'd1);
            chk("bp_addr_stable", 64'(mem_req_block_addr), 64'h2031);
            @(negedge clk);
        end
        mem_req_ready = 1'b1;
        @(negedge clk);
        chk("bp_one_handshake", 64'(dut_hs - hs0), 64'd1);
        chk("bp_no_early_fill", 64'(fill_valid), 64'd0);
        respond(29'h2031, 64'h1122_3344_5566_7788);
        chk("bp_fill", 64'(fill_valid), 64'd1);
        chk("bp_data", fill_data, 64'h1122_3344_5566_7788);
        @(negedge clk);

        // Mismatched response ignored
        issue_miss(32'h0001_018c, 1'b1);
        @(negedge clk);
        respond(29'h2032, 64'hdead_beef_dead_beef);
        chk("mm_no_fill", 64'(fill_valid), 64'd0);
        chk("mm_still_busy", 64'(busy), 64'd1);
        respond(29'h2031, 64'h0bad_cafe_0000_0001);
        chk("mm_fill", 64'(fill_valid), 64'd1);
        chk("mm_data", fill_data, 64'h0bad_cafe_0000_0001);
        @(negedge clk);

        // Flush in WAIT then drain
        issue_miss(32'h0001_018c, 1'b1);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        respond(29'h2031, 64'h5555_aaaa_5555_aaaa);
        chk("fl_no_fill", 64'(fill_valid), 64'd0);
        chk("fl_idle", 64'(miss_ready), 64'd1);
        issue_miss(32'h0001_0194, 1'b0);
        @(negedge clk);
        respond(29'h2032, 64'h0123_4567_89ab_cdef);
        chk("fl_next_fill", 64'(fill_valid), 64'd1);
        chk("fl_next_index", 64'(fill_index), 64'h32);
        chk("fl_next_tag", 64'(fill_tag), 64'h80);
        @(negedge clk);

        // Asynchronous reset mid-WAIT
        issue_miss(32'h0001_018c, 1'b1);
        @(negedge clk);
        #3 rst = 1'b1;
        #1;
        chk("ar_miss_ready", 64'(miss_ready), 64'd1);
        chk("ar_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        respond(29'h2031, 64'hffff_0000_ffff_0000);
        chk("ar_no_fill", 64'(fill_valid), 64'd0);
        chk("ar_idle", 64'(miss_ready), 64'd1);
        @(negedge clk);

`ifdef ICACHE_FILL_TIMEOUT_EN
        // Timeout re-request
        issue_miss(32'h0001_018c, 1'b1);
        @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chk("to_waiting", 64'(mem_req_valid), 64'd0);
        end
        @(negedge clk);
        chk("to_rereq", 64'(mem_req_valid), 64'd1);
        chk("to_rereq_addr", 64'(mem_req_block_addr), 64'h2031);
        chk("to_err", 64'(timeout_err), 64'd1);
        @(negedge clk);
        respond(29'h2031, 64'h7777_6666_5555_4444);
        chk("to_fill", 64'(fill_valid), 64'd1);
        @(negedge clk);
`endif

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            miss_valid      = ($urandom_range(0, 1) == 0);
            miss_addr       = $urandom();
            miss_victim_way = 1'($urandom_range(0, 1));
            flush           = ($urandom_range(0, 19) == 0);
            mem_req_ready   = ($urandom_range(0, 9) < 6);
            mem_resp_valid  = ($urandom_range(0, 9) < 3);
            case ($urandom_range(0, 3))
                0:       mem_resp_block_addr = m_blk + 1'b1;
                1:       mem_resp_block_addr = BW'($urandom());
                default: mem_resp_block_addr = m_blk;
            endcase
            mem_resp_data = {$urandom(), $urandom()};
            @(negedge clk);
        end
        miss_valid     = 1'b0;
        flush          = 1'b0;
        mem_resp_valid = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
